// File: rtl/vram_arbiter.sv
// Purpose: shares one VRAM port between display (DSP), host CPU and draw engine (DRW); routes read-data-valid back by tag.
// Latency: grant one cycle after a request is seen in IDLE; ACK and RDATAVLD are combinational in the cycle VIF responds.
// Backpressure: VRAM_ACK gates every beat; reads are held off while the outstanding-read tag FIFO is full.
// Ports: CLK/RST_X clock and async active-low reset; <x>_REQ/WRITE/ADR/WDATA/DMASK requester side;
//        <x>_ACK/<x>_RDATAVLD per-requester responses; VRAM_* to/from the VRAM interface controller;
//        OWNER current owner (0 none, 1 DSP, 2 CPU, 3 DRW); ERROR sticky tag FIFO underflow[0]/overflow[1].
module vram_arbiter #(
    parameter int DW          = 64,
    parameter int BURST       = 16,
    parameter int TAGDEPTH    = 8,
    parameter int DRW_MAXWAIT = 256
) (
    input  logic            CLK,
    input  logic            RST_X,
    input  logic            DSP_REQ,
    input  logic            CPU_REQ,
    input  logic            DRW_REQ,
    input  logic            DSP_WRITE,
    input  logic            CPU_WRITE,
    input  logic            DRW_WRITE,
    input  logic [22:0]     DSP_ADR,
    input  logic [22:0]     CPU_ADR,
    input  logic [22:0]     DRW_ADR,
    input  logic [DW-1:0]   CPU_WDATA,
    input  logic [DW-1:0]   DRW_WDATA,
    input  logic [DW/8-1:0] CPU_DMASK,
    input  logic [DW/8-1:0] DRW_DMASK,
    output logic            DSP_ACK,
    output logic            CPU_ACK,
    output logic            DRW_ACK,
    output logic            DSP_RDATAVLD,
    output logic            CPU_RDATAVLD,
    output logic            DRW_RDATAVLD,
    output logic            VRAM_REQ,
    output logic            VRAM_WRITE,
    output logic [22:0]     VRAM_ADR,
    output logic [DW-1:0]   VRAM_WDATA,
    output logic [DW/8-1:0] VRAM_DMASK,
    input  logic            VRAM_ACK,
    input  logic            VRAM_RDATAVLD,
    output logic [1:0]      OWNER,
    output logic [1:0]      ERROR
);

    localparam int MW = DW / 8;
    localparam int AW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int WW = $clog2(DRW_MAXWAIT + 1);

    // State encoding doubles as the OWNER code and as the read tag value.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_DSP = 2'd1,
        OWN_CPU = 2'd2,
        OWN_DRW = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]   drw_wait_q, drw_wait_d;
    logic [1:0]      tag_mem_q [TAGDEPTH];
    logic [1:0]      tag_mem_d [TAGDEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     tag_cnt_q, tag_cnt_d;
    logic [1:0]      error_q, error_d;

    logic            own_req, own_write;
    logic [22:0]     own_adr;
    logic [DW-1:0]   own_wdata;
    logic [MW-1:0]   own_mask;
    logic            tag_full, tag_empty, accept, push, pop;
    logic [1:0]      tag_head;

    // The display path is read-only; its write strobe has nowhere to go.
    logic unused_dsp_write;
    assign unused_dsp_write = DSP_WRITE;

    // Owner multiplexer; everything stays zero while idle.
    always_comb begin
        own_req   = 1'b0;
        own_write = 1'b0;
        own_adr   = '0;
        own_wdata = '0;
        own_mask  = '0;
        case (state_q)
            OWN_DSP: begin
                own_req = DSP_REQ;
                own_adr = DSP_ADR;
            end
            OWN_CPU: begin
                own_req   = CPU_REQ;
                own_write = CPU_WRITE;
                own_adr   = CPU_ADR;
                own_wdata = CPU_WDATA;
                own_mask  = CPU_DMASK;
            end
            OWN_DRW: begin
                own_req   = DRW_REQ;
                own_write = DRW_WRITE;
                own_adr   = DRW_ADR;
                own_wdata = DRW_WDATA;
                own_mask  = DRW_DMASK;
            end
            default: ;
        endcase
    end

    assign tag_full   = (tag_cnt_q == (AW+1)'(TAGDEPTH));
    assign tag_empty  = (tag_cnt_q == '0);
    assign tag_head   = tag_mem_q[rd_ptr_q];

    assign VRAM_REQ   = own_req & ~(~own_write & tag_full);
    assign VRAM_WRITE = own_write;
    assign VRAM_ADR   = own_adr;
    assign VRAM_WDATA = own_wdata;
    assign VRAM_DMASK = own_mask;

    assign accept  = VRAM_REQ & VRAM_ACK;
    assign push    = accept & ~own_write;
    assign pop     = VRAM_RDATAVLD & ~tag_empty;

    assign DSP_ACK = accept & (state_q == OWN_DSP);
    assign CPU_ACK = accept & (state_q == OWN_CPU);
    assign DRW_ACK = accept & (state_q == OWN_DRW);

    assign DSP_RDATAVLD = pop & (tag_head == 2'd1);
    assign CPU_RDATAVLD = pop & (tag_head == 2'd2);
    assign DRW_RDATAVLD = pop & (tag_head == 2'd3);

    assign OWNER = state_q;
    assign ERROR = error_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        drw_wait_d = drw_wait_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tag_cnt_d  = tag_cnt_q;
        error_d    = error_q;

        if (state_q == IDLE) begin
            // A DRW that has waited long enough jumps ahead of the CPU, never the display.
            if (DSP_REQ)
                state_d = OWN_DSP;
            else if (DRW_REQ && (drw_wait_q >= WW'(DRW_MAXWAIT)))
                state_d = OWN_DRW;
            else if (CPU_REQ)
                state_d = OWN_CPU;
            else if (DRW_REQ)
                state_d = OWN_DRW;
        end else begin
            // Ownership always drops back to IDLE so every handover re-arbitrates.
            if (!own_req) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else if (accept) begin
                if (beat_cnt_q == CW'(BURST - 1)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
        end

        if (!DRW_REQ || (state_q != OWN_DRW && state_d == OWN_DRW))
            drw_wait_d = '0;
        else if (state_q != OWN_DRW && drw_wait_q < WW'(DRW_MAXWAIT))
            drw_wait_d = drw_wait_q + WW'(1);

        if (push) begin
            tag_mem_d[wr_ptr_q] = state_q;
            wr_ptr_d            = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   tag_cnt_d = tag_cnt_q + (AW+1)'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - (AW+1)'(1);
            default: ;
        endcase

        if (VRAM_RDATAVLD && tag_empty)
            error_d[0] = 1'b1;
        if (push && tag_full)
            error_d[1] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            drw_wait_q <= '0;
            for (int i = 0; i < TAGDEPTH; i++)
                tag_mem_q[i] <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
            error_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            drw_wait_q <= drw_wait_d;
            tag_mem_q  <= tag_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_cnt_q  <= tag_cnt_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose: self-checking bench for vram_arbiter with a VIF model and a read-return scoreboard.
// Latency: VIF model acks combinationally and returns read data a configurable number of cycles after each read ack.
// Backpressure: VIF returns can be held to fill the tag FIFO and released one pulse at a time.
module tb_vram_arbiter;

    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int MAXW = 8;

    logic          CLK, RST_X;
    logic          DSP_REQ, CPU_REQ, DRW_REQ;
    logic          DSP_WRITE, CPU_WRITE, DRW_WRITE;
    logic [22:0]   DSP_ADR, CPU_ADR, DRW_ADR;
    logic [DW-1:0] CPU_WDATA, DRW_WDATA;
    logic [MW-1:0] CPU_DMASK, DRW_DMASK;
    logic          DSP_ACK, CPU_ACK, DRW_ACK;
    logic          DSP_RDATAVLD, CPU_RDATAVLD, DRW_RDATAVLD;
    logic          VRAM_REQ, VRAM_WRITE;
    logic [22:0]   VRAM_ADR;
    logic [DW-1:0] VRAM_WDATA;
    logic [MW-1:0] VRAM_DMASK;
    logic          VRAM_ACK, VRAM_RDATAVLD;
    logic [1:0]    OWNER, ERROR;

    vram_arbiter #(.DW(DW), .BURST(16), .TAGDEPTH(8), .DRW_MAXWAIT(MAXW)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .DSP_REQ(DSP_REQ), .CPU_REQ(CPU_REQ), .DRW_REQ(DRW_REQ),
        .DSP_WRITE(DSP_WRITE), .CPU_WRITE(CPU_WRITE), .DRW_WRITE(DRW_WRITE),
        .DSP_ADR(DSP_ADR), .CPU_ADR(CPU_ADR), .DRW_ADR(DRW_ADR),
        .CPU_WDATA(CPU_WDATA), .DRW_WDATA(DRW_WDATA),
        .CPU_DMASK(CPU_DMASK), .DRW_DMASK(DRW_DMASK),
        .DSP_ACK(DSP_ACK), .CPU_ACK(CPU_ACK), .DRW_ACK(DRW_ACK),
        .DSP_RDATAVLD(DSP_RDATAVLD), .CPU_RDATAVLD(CPU_RDATAVLD), .DRW_RDATAVLD(DRW_RDATAVLD),
        .VRAM_REQ(VRAM_REQ), .VRAM_WRITE(VRAM_WRITE), .VRAM_ADR(VRAM_ADR),
        .VRAM_WDATA(VRAM_WDATA), .VRAM_DMASK(VRAM_DMASK),
        .VRAM_ACK(VRAM_ACK), .VRAM_RDATAVLD(VRAM_RDATAVLD),
        .OWNER(OWNER), .ERROR(ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] id);
        onehot = (id == 2'd0) ? 3'b000 : (3'b001 << (id - 2'd1));
    endfunction

    // VIF model and read-return scoreboard.
    int         due_q[$];
    logic [1:0] sb_q[$];
    bit         vif_hold  = 0;
    bit         vif_force = 0;
    int         lat       = 4;

    initial begin
        logic [2:0] routing;
        logic [1:0] id;
        VRAM_RDATAVLD = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (!RST_X) begin
                due_q.delete();
                sb_q.delete();
                VRAM_RDATAVLD = 1'b0;
            end else if (vif_force) begin
                VRAM_RDATAVLD = 1'b1;
            end else if (!vif_hold && due_q.size() > 0 && due_q[0] <= cyc) begin
                VRAM_RDATAVLD = 1'b1;
                void'(due_q.pop_front());
            end else begin
                VRAM_RDATAVLD = 1'b0;
            end
            @(negedge CLK);
            if (RST_X) begin
                routing = {DRW_RDATAVLD, CPU_RDATAVLD, DSP_RDATAVLD};
                if (VRAM_RDATAVLD) begin
                    if (vif_force || sb_q.size() == 0) begin
                        chk("rdv_empty_route", routing, 3'b000);
                    end else begin
                        id = sb_q.pop_front();
                        chk("rdv_route", routing, onehot(id));
                    end
                end else if (routing != 3'b000) begin
                    chk("rdv_spurious", routing, 3'b000);
                end
                if (VRAM_REQ && VRAM_ACK && !VRAM_WRITE) begin
                    due_q.push_back(cyc + lat);
                    sb_q.push_back(DSP_ACK ? 2'd1 : CPU_ACK ? 2'd2 : DRW_ACK ? 2'd3 : 2'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (due_q.size() > 0 || sb_q.size() > 0 || OWNER != 2'd0); i++)
            step();
        smp();
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST_X = 1'b0; VRAM_ACK = 1'b0;
        DSP_REQ = 0; CPU_REQ = 1; DRW_REQ = 0;
        DSP_WRITE = 0; CPU_WRITE = 1; DRW_WRITE = 0;
        DSP_ADR = '0; CPU_ADR = 23'h1AAAA; DRW_ADR = '0;
        CPU_WDATA = 64'hDEADBEEF_CAFEF00D; DRW_WDATA = '0;
        CPU_DMASK = 8'hFF; DRW_DMASK = '0;

        // Reset state with a request already present.
        repeat (3) step();
        smp();
        chk("rst_owner", OWNER, 2'd0);
        chk("rst_vram_req", VRAM_REQ, 1'b0);
        chk("rst_vram_write", VRAM_WRITE, 1'b0);
        chk("rst_vram_adr", VRAM_ADR, 23'd0);
        chk("rst_vram_wdata", VRAM_WDATA, 64'd0);
        chk("rst_vram_dmask", VRAM_DMASK, 8'd0);
        chk("rst_acks", {DSP_ACK, CPU_ACK, DRW_ACK}, 3'b000);
        chk("rst_error", ERROR, 2'b00);
        CPU_REQ = 0; CPU_WRITE = 0;
        step();
        RST_X = 1'b1; VRAM_ACK = 1'b1; lat = 4;

        // Test 1: DRW read burst, re-arbitration after 16 beats.
        step();
        DRW_REQ = 1; DRW_WRITE = 0; DRW_ADR = 23'h000123;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) step();
            smp();
            chk("t1_owner", OWNER, ((k >= 1 && k <= 16) || k == 18) ? 2'd3 : 2'd0);
            chk("t1_drw_ack", DRW_ACK, ((k >= 1 && k <= 16) || k == 18) ? 1'b1 : 1'b0);
            if (k == 1) chk("t1_adr", VRAM_ADR, 23'h000123);
        end
        step();
        DRW_REQ = 0;
        drain();

        // Test 2: DSP beats DRW; DRW follows after one IDLE cycle.
        step();
        DSP_REQ = 1; DSP_WRITE = 0; DSP_ADR = 23'h000400;
        DRW_REQ = 1; DRW_WRITE = 0; DRW_ADR = 23'h000500;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            if (k == 5) DSP_REQ = 0;
            smp();
            chk("t2_owner", OWNER, (k >= 1 && k <= 5) ? 2'd1 : (k == 7) ? 2'd3 : 2'd0);
            chk("t2_dsp_ack", DSP_ACK, (k >= 1 && k <= 4) ? 1'b1 : 1'b0);
            chk("t2_drw_ack", DRW_ACK, (k == 7) ? 1'b1 : 1'b0);
            if (k == 1) chk("t2_dsp_adr", VRAM_ADR, 23'h000400);
            if (k == 7) chk("t2_drw_adr", VRAM_ADR, 23'h000500);
        end
        step();
        DRW_REQ = 0;
        drain();

        // Test 3: starved DRW outranks a continuous CPU stream.
        step();
        CPU_REQ = 1; CPU_WRITE = 1; CPU_ADR = 23'h000777;
        CPU_WDATA = 64'hC0C0C0C0_12345678; CPU_DMASK = 8'h0F;
        DRW_REQ = 1; DRW_WRITE = 1; DRW_ADR = 23'h000888;
        DRW_WDATA = 64'hD4D4D4D4_87654321; DRW_DMASK = 8'hF0;
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) step();
            if (k == 19) DRW_REQ = 0;
            smp();
            chk("t3_owner", OWNER, (k >= 1 && k <= 16) ? 2'd2 : (k == 18 || k == 19) ? 2'd3 :
                                   (k == 21) ? 2'd2 : 2'd0);
            chk("t3_cpu_ack", CPU_ACK, ((k >= 1 && k <= 16) || k == 21) ? 1'b1 : 1'b0);
            chk("t3_drw_ack", DRW_ACK, (k == 18) ? 1'b1 : 1'b0);
            if (k == 1) begin
                chk("t3_cpu_write", VRAM_WRITE, 1'b1);
                chk("t3_cpu_wdata", VRAM_WDATA, 64'hC0C0C0C0_12345678);
                chk("t3_cpu_dmask", VRAM_DMASK, 8'h0F);
            end
            if (k == 18) begin
                chk("t3_drw_write", VRAM_WRITE, 1'b1);
                chk("t3_drw_wdata", VRAM_WDATA, 64'hD4D4D4D4_87654321);
                chk("t3_drw_dmask", VRAM_DMASK, 8'hF0);
            end
        end
        step();
        CPU_REQ = 0; CPU_WRITE = 0;
        drain();

        // Test 4: tag FIFO full holds reads; one return frees a single slot.
        vif_hold = 1;
        step();
        DRW_REQ = 1; DRW_WRITE = 0; DRW_ADR = 23'h7FFFFF;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) step();
            if (k == 11) vif_hold = 0;
            if (k == 12) vif_hold = 1;
            smp();
            chk("t4_vram_req", VRAM_REQ, ((k >= 1 && k <= 8) || k == 12) ? 1'b1 : 1'b0);
            chk("t4_drw_ack", DRW_ACK, ((k >= 1 && k <= 8) || k == 12) ? 1'b1 : 1'b0);
            chk("t4_owner", OWNER, (k >= 1) ? 2'd3 : 2'd0);
            if (k == 11) chk("t4_drw_rdv", DRW_RDATAVLD, 1'b1);
        end
        step();
        DRW_REQ = 0; vif_hold = 0;
        drain();

        // Test 5: CPU read then DSP read return in issue order.
        lat = 4;
        step();
        CPU_REQ = 1; CPU_WRITE = 0; CPU_ADR = 23'h000010;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            if (k == 2) begin
                CPU_REQ = 0;
                DSP_REQ = 1; DSP_ADR = 23'h000020;
            end
            if (k == 5) DSP_REQ = 0;
            smp();
            chk("t5_cpu_rdv", CPU_RDATAVLD, (k == 5) ? 1'b1 : 1'b0);
            chk("t5_dsp_rdv", DSP_RDATAVLD, (k == 8) ? 1'b1 : 1'b0);
        end
        drain();

        // Test 6: underflow error is sticky; reset mid-transfer clears everything.
        step();
        vif_force = 1;
        smp();
        chk("t6_error_before", ERROR, 2'b00);
        step();
        vif_force = 0;
        smp();
        chk("t6_error_set", ERROR, 2'b01);
        repeat (3) step();
        smp();
        chk("t6_error_held", ERROR, 2'b01);
        step();
        DRW_REQ = 1; DRW_WRITE = 0; DRW_ADR = 23'h000321;
        step();
        step();
        smp();
        chk("t6_owner_drw", OWNER, 2'd3);
        chk("t6_vram_req_on", VRAM_REQ, 1'b1);
        step();
        RST_X = 1'b0;
        smp();
        chk("t6_rst_vram_req", VRAM_REQ, 1'b0);
        chk("t6_rst_owner", OWNER, 2'd0);
        chk("t6_rst_error", ERROR, 2'b00);
        chk("t6_rst_drw_ack", DRW_ACK, 1'b0);
        step();
        DRW_REQ = 0;
        step();
        RST_X = 1'b1;
        step();
        smp();
        chk("t6_post_owner", OWNER, 2'd0);
        chk("t6_post_error", ERROR, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
